// File: rtl/shift_pkg.sv
// Shared definitions for the shift/rotate sequencer: op encodings, FSM state type, default widths.
package shift_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 3;

    localparam logic [1:0] OP_SHL = 2'b00;
    localparam logic [1:0] OP_SHR = 2'b01;
    localparam logic [1:0] OP_ROL = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Request/result handshake bundle for shift_seq_ctrl; out_z exists only with SHIFT_ZFLAG_EN.
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [CNT_W-1:0] in_count;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_c;
    logic             busy;
`ifdef SHIFT_ZFLAG_EN
    logic             out_z;
`endif

    modport master (
        output in_valid, in_data, in_count, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_c, busy
`ifdef SHIFT_ZFLAG_EN
        , input out_z
`endif
    );

    modport slave (
        input  in_valid, in_data, in_count, in_op, out_ready,
        output in_ready, out_valid, out_result, out_c, busy
`ifdef SHIFT_ZFLAG_EN
        , output out_z
`endif
    );
endinterface

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate step; returns next data and the bit moved out or wrapped.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] data_next,
    output logic             c_next
);

    always_comb begin
        data_next = data;
        c_next    = 1'b0;
        case (op)
            OP_SHL: begin
                data_next = {data[WIDTH-2:0], 1'b0};
                c_next    = data[WIDTH-1];
            end
            OP_SHR: begin
                data_next = {1'b0, data[WIDTH-1:1]};
                c_next    = data[0];
            end
            OP_ROL: begin
                data_next = {data[WIDTH-2:0], data[WIDTH-1]};
                c_next    = data[WIDTH-1];
            end
            default: begin
                data_next = {data[0], data[WIDTH-1:1]};
                c_next    = data[0];
            end
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift/rotate sequencer: one bit position per clock, result plus carry on a valid/ready port.
// Optional zero flag output enabled by defining SHIFT_ZFLAG_EN.
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    shift_seq_ctrl_if.slave bus
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] data_r;
    logic [1:0]       op_r;
    logic             c_r;
    logic [WIDTH-1:0] step_data;
    logic             step_c;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             busy_c;
    logic             accept;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .data      (data_r),
        .op        (op_r),
        .data_next (step_data),
        .c_next    (step_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b1;
        case (state)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                busy_c     = 1'b0;
                if (bus.in_valid)
                    state_nxt = (bus.in_count != '0) ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_W'(1)) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign accept = in_ready_c & bus.in_valid;

    // Working register doubles as the result; it keeps the last result through IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= '0;
            op_r   <= OP_SHL;
            cnt_r  <= '0;
            c_r    <= 1'b0;
        end else if (accept) begin
            data_r <= bus.in_data;
            op_r   <= bus.in_op;
            cnt_r  <= bus.in_count;
            c_r    <= 1'b0;
        end else if (state == ST_SHIFT) begin
            data_r <= step_data;
            c_r    <= step_c;
            cnt_r  <= cnt_r - CNT_W'(1);
        end
    end

`ifdef SHIFT_ZFLAG_EN
    logic z_r;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    z_r <= 1'b0;
        else if (accept)            z_r <= (bus.in_data == '0);
        else if (state == ST_SHIFT) z_r <= (step_data == '0);
    end
    assign bus.out_z = z_r;
`endif

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_c;
    assign bus.busy       = busy_c;
    assign bus.out_result = data_r;
    assign bus.out_c      = c_r;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Randomized and directed bench for shift_seq_ctrl against an arithmetic shift/rotate model.
module tb_shift_seq_ctrl;
    import shift_pkg::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    shift_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Whole shift done at once: n-position shift/rotate, carry is the last bit out or wrapped.
    task automatic model(input logic [7:0] d, input int n, input logic [1:0] op,
                         output logic [7:0] r, output logic c);
        logic [15:0] w;
        w = {8'h00, d};
        r = d;
        c = 1'b0;
        case (op)
            OP_SHL: begin r = 8'((w << n) & 16'hFF); if (n > 0) c = d[8-n]; end
            OP_SHR: begin r = 8'(w >> n);            if (n > 0) c = d[n-1]; end
            OP_ROL: begin r = 8'(((w << n) | (w >> (8 - n))) & 16'hFF); if (n > 0) c = r[0]; end
            default: begin r = 8'(((w >> n) | (w << (8 - n))) & 16'hFF); if (n > 0) c = r[7]; end
        endcase
    endtask

    task automatic run_txn(input logic [7:0] d, input int n, input logic [1:0] op,
                           input int hold, input logic [7:0] er, input logic ec);
        int lat;
        @(posedge clk); #1;
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_count = CNT_W'(n);
        bus.in_op    = op;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        chk("accept_busy", 32'(bus.busy), 32'd1);
        chk("accept_in_ready", 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(n));
        chk("done_busy", 32'(bus.busy), 32'd1);
        repeat (hold) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            bus.in_count = CNT_W'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_result", 32'(bus.out_result), 32'(er));
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid = 1'b0;
        chk("result", 32'(bus.out_result), 32'(er));
        chk("carry", 32'(bus.out_c), 32'(ec));
`ifdef SHIFT_ZFLAG_EN
        chk("zflag", 32'(bus.out_z), 32'(er == 8'h00));
`endif
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("post_valid", 32'(bus.out_valid), 32'd0);
        chk("post_busy", 32'(bus.busy), 32'd0);
        chk("post_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_result_kept", 32'(bus.out_result), 32'(er));
    endtask

    typedef struct {
        logic [7:0] d;
        int         n;
        logic [1:0] op;
        int         hold;
        logic [7:0] er;
        logic       ec;
    } vec_t;

    vec_t vecs[7] = '{
        '{8'h81, 1, OP_SHL, 0, 8'h02, 1'b1},
        '{8'h03, 1, OP_SHR, 0, 8'h01, 1'b1},
        '{8'h80, 7, OP_SHR, 0, 8'h01, 1'b0},
        '{8'hC0, 2, OP_ROL, 0, 8'h03, 1'b1},
        '{8'h01, 3, OP_ROR, 0, 8'h20, 1'b0},
        '{8'h5A, 0, OP_ROL, 0, 8'h5A, 1'b0},
        '{8'h01, 3, OP_SHL, 5, 8'h08, 1'b0}
    };

    initial begin
        logic [7:0] r;
        logic       c;
        logic [7:0] d;
        int         n;
        logic [1:0] op;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_count  = '0;
        bus.in_op     = '0;
        bus.out_ready = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", 32'(bus.out_result), 32'd0);
        chk("rst_carry", 32'(bus.out_c), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i])
            run_txn(vecs[i].d, vecs[i].n, vecs[i].op, vecs[i].hold, vecs[i].er, vecs[i].ec);

        // Reset in the middle of a ror; the transaction must vanish.
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hFF;
        bus.in_count = CNT_W'(6);
        bus.in_op    = OP_ROR;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_result", 32'(bus.out_result), 32'd0);
        chk("midrst_carry", 32'(bus.out_c), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            chk("midrst_no_pulse", 32'(bus.out_valid), 32'd0);
        end
        run_txn(8'h40, 1, OP_SHL, 0, 8'h80, 1'b0);

        for (int k = 0; k < 40; k++) begin
            d  = 8'($urandom);
            n  = int'($urandom_range(0, 7));
            op = 2'($urandom);
            model(d, n, op, r, c);
            run_txn(d, n, op, int'($urandom_range(0, 3)), r, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
